// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; on resolve it scores the prediction, issues a
// registered BHT update one cycle later, and on a mispredict issues a redirect and flushes all younger entries.
module branch_resolve_queue #(
    parameter int LOWER = 5,
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic             fetch_pred,
    input  logic [PC_W-1:0]  fetch_target,
    output logic             fetch_ready,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic             resolve_jump,
    input  logic [PC_W-1:0]  resolve_target,
    output logic             upd_en,
    output logic [LOWER-1:0] upd_addr,
    output logic             upd_taken,
    output logic             upd_jumped,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             underflow_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic             pred_mem[DEPTH];
    logic [PC_W-1:0]  tgt_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             upd_en_q, upd_taken_q, upd_jumped_q, redirect_valid_q, underflow_q;
    logic [LOWER-1:0] upd_addr_q;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] mis_cnt_q;

    logic [PC_W-1:0]  head_pc, head_tgt;
    logic             head_pred, actual, mispredict, do_pop, do_push, flush;

    assign fetch_ready = (count_q != FULL_CNT);

    always_comb begin
        head_pc    = pc_mem[head_q];
        head_pred  = pred_mem[head_q];
        head_tgt   = tgt_mem[head_q];
        actual     = resolve_taken | resolve_jump;
        mispredict = (actual != head_pred) | (actual & head_pred & (resolve_target != head_tgt));
        do_pop     = resolve_valid && (count_q != '0);
        do_push    = fetch_valid && fetch_ready;
        flush      = do_pop && mispredict;
        redirect_pc_d = actual ? resolve_target : head_pc + PC_W'(4);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // Everything behind a mispredicted branch is wrong-path, including a same-cycle push.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop)
                head_d = head_q + 1'b1;
            if (do_push)
                tail_d = tail_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[tail_q]   <= fetch_pc;
            pred_mem[tail_q] <= fetch_pred;
            tgt_mem[tail_q]  <= fetch_target;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            upd_en_q         <= 1'b0;
            upd_addr_q       <= '0;
            upd_taken_q      <= 1'b0;
            upd_jumped_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mis_cnt_q        <= '0;
            underflow_q      <= 1'b0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            upd_en_q         <= do_pop;
            redirect_valid_q <= flush;
            if (do_pop) begin
                upd_addr_q   <= head_pc[LOWER+1:2];
                upd_taken_q  <= resolve_taken;
                upd_jumped_q <= resolve_jump;
            end
            if (flush) begin
                redirect_pc_q <= redirect_pc_d;
                if (mis_cnt_q != CNT_MAX)
                    mis_cnt_q <= mis_cnt_q + 1'b1;
            end
            if (resolve_valid && (count_q == '0))
                underflow_q <= 1'b1;
        end
    end

    assign upd_en         = upd_en_q;
    assign upd_addr       = upd_addr_q;
    assign upd_taken      = upd_taken_q;
    assign upd_jumped     = upd_jumped_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = mis_cnt_q;
    assign underflow_err  = underflow_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed stimulus for branch_resolve_queue; expected update/redirect pulses go to a scoreboard
// that a negedge monitor drains whenever upd_en is seen.
module tb_branch_resolve_queue;
    localparam int LOWER = 5;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             arst;
    logic             fetch_valid, fetch_pred, fetch_ready;
    logic [PC_W-1:0]  fetch_pc, fetch_target;
    logic             resolve_valid, resolve_taken, resolve_jump;
    logic [PC_W-1:0]  resolve_target;
    logic             upd_en, upd_taken, upd_jumped, redirect_valid, underflow_err;
    logic [LOWER-1:0] upd_addr;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    branch_resolve_queue #(.LOWER(LOWER), .DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred(fetch_pred),
        .fetch_target(fetch_target), .fetch_ready(fetch_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_jump(resolve_jump),
        .resolve_target(resolve_target),
        .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken), .upd_jumped(upd_jumped),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOWER-1:0] addr;
        logic             taken;
        logic             jumped;
        logic             redir;
        logic [PC_W-1:0]  rpc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!arst) begin
            if (upd_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_upd: got upd_en=1 addr=0x%0h expected no update", upd_addr);
                end else begin
                    e = sb.pop_front();
                    chk("upd_addr", 64'(upd_addr), 64'(e.addr));
                    chk("upd_taken", 64'(upd_taken), 64'(e.taken));
                    chk("upd_jumped", 64'(upd_jumped), 64'(e.jumped));
                    chk("redirect_valid", 64'(redirect_valid), 64'(e.redir));
                    chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
                    chk("mispredict_cnt", 64'(mispredict_cnt), 64'(e.cnt));
                end
            end else if (redirect_valid) begin
                checks++;
                errors++;
                $display("FAIL stray_redirect: got redirect_valid=1 expected 0 without upd_en");
            end
        end
    end

    task automatic cyc(input logic fv, input logic [PC_W-1:0] pc, input logic pred,
                       input logic [PC_W-1:0] tgt, input logic rv, input logic rt,
                       input logic rj, input logic [PC_W-1:0] rtgt);
        fetch_valid = fv; fetch_pc = pc; fetch_pred = pred; fetch_target = tgt;
        resolve_valid = rv; resolve_taken = rt; resolve_jump = rj; resolve_target = rtgt;
        @(posedge clk);
        #1;
        fetch_valid = 0; fetch_pc = '0; fetch_pred = 0; fetch_target = '0;
        resolve_valid = 0; resolve_taken = 0; resolve_jump = 0; resolve_target = '0;
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic pred, input logic [PC_W-1:0] tgt);
        cyc(1'b1, pc, pred, tgt, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic expect_upd(input logic [LOWER-1:0] a, input logic t, input logic j,
                              input logic r, input logic [PC_W-1:0] rpc, input logic [CNT_W-1:0] c);
        exp_t x;
        x.addr = a; x.taken = t; x.jumped = j; x.redir = r; x.rpc = rpc; x.cnt = c;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        #2 arst = 1'b1;
        #1;
        chk("async_rst_fetch_ready", 64'(fetch_ready), 64'd1);
        @(posedge clk);
        #1 arst = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        fetch_valid = 0; fetch_pc = '0; fetch_pred = 0; fetch_target = '0;
        resolve_valid = 0; resolve_taken = 0; resolve_jump = 0; resolve_target = '0;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;

        chk("rst_upd_en", 64'(upd_en), 64'd0);
        chk("rst_upd_addr", 64'(upd_addr), 64'd0);
        chk("rst_upd_taken", 64'(upd_taken), 64'd0);
        chk("rst_upd_jumped", 64'(upd_jumped), 64'd0);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_mispredict_cnt", 64'(mispredict_cnt), 64'd0);
        chk("rst_underflow", 64'(underflow_err), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);

        // Reset with 3 queued: afterwards a full 4 pushes must fit before fetch_ready drops.
        push(32'h20, 1'b0, '0); push(32'h24, 1'b0, '0); push(32'h28, 1'b0, '0);
        do_reset();
        push(32'h20, 1'b0, '0); push(32'h24, 1'b0, '0); push(32'h28, 1'b0, '0);
        chk("post_rst_ready_3", 64'(fetch_ready), 64'd1);
        push(32'h2C, 1'b0, '0);
        chk("post_rst_full_4", 64'(fetch_ready), 64'd0);
        do_reset();

        push(32'h40, 1'b1, 32'h80);
        expect_upd(5'h10, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h80);

        push(32'h100, 1'b0, '0);
        expect_upd(5'h00, 1'b1, 1'b0, 1'b1, 32'h200, 3'd1);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h200);

        push(32'h10C, 1'b1, 32'h300);
        expect_upd(5'h03, 1'b0, 1'b0, 1'b1, 32'h110, 3'd2);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

        // Fill, overflow, push+pop while full, then wrap with order preserved.
        push(32'h04, 1'b0, '0); push(32'h08, 1'b0, '0); push(32'h0C, 1'b0, '0);
        chk("fill_ready_3", 64'(fetch_ready), 64'd1);
        push(32'h10, 1'b0, '0);
        chk("fill_ready_4", 64'(fetch_ready), 64'd0);
        push(32'h14, 1'b0, '0);
        expect_upd(5'h01, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b1, 32'h18, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("full_pushpop_ready", 64'(fetch_ready), 64'd1);
        expect_upd(5'h02, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b1, 32'h1C, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("pushpop_ready_3", 64'(fetch_ready), 64'd1);
        expect_upd(5'h03, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b1, 32'h20, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        expect_upd(5'h04, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b1, 32'h24, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        expect_upd(5'h07, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b1, 32'h28, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("wrap_ready_3", 64'(fetch_ready), 64'd1);
        expect_upd(5'h08, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        expect_upd(5'h09, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        expect_upd(5'h0A, 1'b0, 1'b0, 1'b0, 32'h110, 3'd2);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

        // Target mismatch on the oldest of 3 flushes everything, including the same-cycle push.
        push(32'h30, 1'b1, 32'h500); push(32'h34, 1'b0, '0); push(32'h38, 1'b0, '0);
        chk("pre_underflow", 64'(underflow_err), 64'd0);
        expect_upd(5'h0C, 1'b1, 1'b0, 1'b1, 32'h504, 3'd3);
        cyc(1'b1, 32'h3C, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h504);
        chk("flush_ready", 64'(fetch_ready), 64'd1);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("underflow_upd_en", 64'(upd_en), 64'd0);
        chk("underflow_redirect", 64'(redirect_valid), 64'd0);
        chk("underflow_err", 64'(underflow_err), 64'd1);

        // Jumps predicted not-taken: counter 4,5,6,7 then holds at 7.
        for (int i = 0; i < 6; i++) begin
            push(32'h40 + 32'(i * 4), 1'b0, '0);
            expect_upd(5'(5'h10 + i), 1'b0, 1'b1, 1'b1, 32'h900, 3'((4 + i > 7) ? 7 : 4 + i));
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h900);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("underflow_sticky", 64'(underflow_err), 64'd1);
        chk("final_cnt_sat", 64'(mispredict_cnt), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks in-flight branch predictions between fetch and execute, in program order.
- When a branch resolves in execute, it compares the actual outcome with the recorded prediction.
- It then issues a one-cycle update to the branch history table (index, taken, jumped) and, on a mispredict, a redirect PC plus a flush of younger entries.
- Sits directly downstream of the branch history table's prediction output and upstream of its update port.

Parameters:
LOWER, 5, number of BHT index bits; index taken from pc[LOWER+1:2]
DEPTH, 4, queue entries; power of two, at least 2
PC_W, 32, program counter width
CNT_W, 16, mispredict counter width

Ports:
clk  input  1  clock, rising edge
arst  input  1  asynchronous reset, active-high
fetch_valid  input  1  branch/jump fetched this cycle; push request
fetch_pc  input  PC_W  PC of fetched branch
fetch_pred  input  1  BHT prediction (1 = taken)
fetch_target  input  PC_W  predicted target used by fetch
fetch_ready  output  1  queue can accept a push this cycle
resolve_valid  input  1  oldest branch resolved in execute; pop request
resolve_taken  input  1  conditional branch outcome
resolve_jump  input  1  unconditional jump
resolve_target  input  PC_W  actual target address
upd_en  output  1  BHT update strobe
upd_addr  output  LOWER  BHT write index
upd_taken  output  1  registered resolve_taken
upd_jumped  output  1  registered resolve_jump
redirect_valid  output  1  mispredict; fetch must restart
redirect_pc  output  PC_W  restart address
mispredict_cnt  output  CNT_W  saturating mispredict count
underflow_err  output  1  sticky: resolve arrived while queue empty

Behaviour:
- Reset (arst=1, asynchronous): head=tail=count=0, upd_en=0, upd_addr=0, upd_taken=0, upd_jumped=0, redirect_valid=0, redirect_pc=0, mispredict_cnt=0, underflow_err=0. Reset mid-operation discards all entries immediately.
- fetch_ready = (count != DEPTH), combinational from registered count.
- Push: fetch_valid && fetch_ready writes {pc, pred, target} at tail; tail wraps modulo DEPTH. Pushes while full are dropped silently; fetch must honour fetch_ready.
- Pop: resolve_valid && count != 0 reads the head entry; head wraps modulo DEPTH.
- resolve_valid with count == 0: ignored; underflow_err set and held until reset. No update or redirect is issued.
- Simultaneous push and pop with 0 < count < DEPTH: both performed, count unchanged. When count == DEPTH, the pop proceeds and the push is still refused (fetch_ready=0).
- Resolution on a valid pop:
  - actual = resolve_taken | resolve_jump.
  - mispredict = (actual != pred) | (actual & pred & (resolve_target != target)).
- Outputs are registered, one cycle after the pop cycle, and each is a single-cycle pulse:
  - upd_en=1, upd_addr=pc[LOWER+1:2], upd_taken/upd_jumped = registered inputs.
  - redirect_valid = mispredict.
  - redirect_pc = actual ? resolve_target : pc + 4, using PC_W-bit wrap-around arithmetic.
- Flush: on a mispredict pop, all remaining entries are younger and wrong-path. In that same clock edge head=tail=0 and count=0, and any simultaneous push is discarded.
- mispredict_cnt increments by 1 on each mispredict pop and saturates at 2^CNT_W-1. It does not wrap.
- Correct predictions leave redirect_valid=0 and redirect_pc holding its previous value.

Test Plan:
- Reset then idle: all outputs 0, fetch_ready=1. Assert arst while 3 entries are queued: count returns to 0 asynchronously and fetch_ready=1.
- Push pc=0x40 pred=1 target=0x80, then resolve taken=1 target=0x80: next cycle upd_en=1, upd_addr=0x10, upd_taken=1, redirect_valid=0, mispredict_cnt=0.
- Push pc=0x100 pred=0, then resolve taken=1 target=0x200: next cycle redirect_valid=1, redirect_pc=0x200, mispredict_cnt=1. Push pc=0x10C pred=1 target=0x300, then resolve taken=0 jump=0: next cycle redirect_pc=0x110.
- Fill 4 entries: fetch_ready=0 and a 5th push is dropped. Pop in the same cycle as a push: push refused, count=3. Pop an entry carrying a correct prediction together with a push: count stays 3; head/tail wrap with order preserved across 8 pushes/pops.
- Queue 3 entries and mispredict the oldest while fetch_valid=1: the queue empties, the pushed entry is lost, and a subsequent resolve with no push sets underflow_err=1 with upd_en=0.
- Force 2^CNT_W mispredicts (CNT_W overridden to 3, i.e. 8 mispredicts): mispredict_cnt holds at 7.
